vid_in_axi4s_bridge: RTL and testbench



---
 rtl/vid_in_axi4s_bridge.sv | 173 +++++++++++++++++
 tb/tb_vid_in_axi4s_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vid_in_axi4s_bridge.sv
// Video-in to AXI4-Stream bridge: locks to frame timing, holds one pixel to tag end-of-line,
// and buffers {eol, sof, data} words in a first-word-fall-through FIFO with registered outputs.
module vid_in_axi4s_bridge #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FIFO_ADDR_BITS = 5
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    vid_ce,
  input  logic                    vid_active_video,
  input  logic                    vid_vblank,
  input  logic [DATA_WIDTH-1:0]   vid_data,
  output logic [DATA_WIDTH-1:0]   m_axis_video_tdata,
  output logic                    m_axis_video_tvalid,
  input  logic                    m_axis_video_tready,
  output logic                    m_axis_video_tuser,
  output logic                    m_axis_video_tlast,
  output logic                    locked,
  output logic                    overflow,
  input  logic                    overflow_clr,
  output logic [FIFO_ADDR_BITS:0] fifo_level
);

  localparam int unsigned AW    = FIFO_ADDR_BITS;
  localparam int unsigned LW    = FIFO_ADDR_BITS + 1;
  localparam int unsigned WW    = DATA_WIDTH + 2;
  localparam int unsigned DEPTH = 2 ** FIFO_ADDR_BITS;

  typedef enum logic [1:0] {ST_WAIT_VB, ST_WAIT_SOF, ST_RUN} state_t;

  state_t                r_state;
  logic                  r_locked;
  logic                  r_prev_vb;
  logic                  r_sof_pend;
  logic                  r_hold_vld;
  logic                  r_hold_sof;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_overflow;

  logic [WW-1:0]         r_mem [DEPTH];
  logic [AW-1:0]         r_wr;
  logic [AW-1:0]         r_rd;
  logic [LW-1:0]         r_level;
  logic                  r_tvalid;
  logic [WW-1:0]         r_head;

  logic                  w_pop;
  logic                  w_full;
  logic                  w_push_req;
  logic                  w_ovf;
  logic                  w_push;
  logic [WW-1:0]         w_push_word;
  logic                  w_sof_arm;
  logic [LW-1:0]         w_lvl_after_pop;
  logic [AW-1:0]         w_rd_next;
  logic                  w_tvalid_next;
  logic [WW-1:0]         w_head_next;

  assign w_pop           = r_tvalid & m_axis_video_tready;
  assign w_full          = (r_level == LW'(DEPTH));
  // The held pixel leaves on every sample; it is end-of-line when that sample is inactive.
  assign w_push_req      = vid_ce & r_hold_vld;
  assign w_push_word     = {~vid_active_video, r_hold_sof, r_hold_data};
  assign w_ovf           = w_push_req & w_full & ~w_pop;
  assign w_push          = w_push_req & ~w_ovf;
  assign w_sof_arm       = r_sof_pend | (r_prev_vb & ~vid_vblank);
  assign w_lvl_after_pop = r_level - LW'(w_pop);
  assign w_rd_next       = r_rd + AW'(w_pop);

  // Next head of the FIFO: stored word if one remains after the pop, else the word being pushed.
  always_comb begin
    w_tvalid_next = 1'b0;
    w_head_next   = '0;
    if (w_lvl_after_pop != '0) begin
      w_tvalid_next = 1'b1;
      w_head_next   = r_mem[w_rd_next];
    end else if (w_push) begin
      w_tvalid_next = 1'b1;
      w_head_next   = w_push_word;
    end
  end

  // Frame lock FSM and one-pixel hold register; only sample cycles advance it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_WAIT_VB;
      r_locked    <= 1'b0;
      r_prev_vb   <= 1'b0;
      r_sof_pend  <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_sof  <= 1'b0;
      r_hold_data <= '0;
    end else if (vid_ce) begin
      r_prev_vb <= vid_vblank;
      case (r_state)
        ST_WAIT_VB: begin
          if (vid_vblank) r_state <= ST_WAIT_SOF;
        end
        ST_WAIT_SOF: begin
          if (vid_active_video) begin
            r_state     <= ST_RUN;
            r_locked    <= 1'b1;
            r_hold_vld  <= 1'b1;
            r_hold_sof  <= 1'b1;
            r_hold_data <= vid_data;
            r_sof_pend  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_ovf) begin
            r_state    <= ST_WAIT_VB;
            r_locked   <= 1'b0;
            r_hold_vld <= 1'b0;
            r_sof_pend <= 1'b0;
          end else if (vid_active_video) begin
            r_hold_vld  <= 1'b1;
            r_hold_sof  <= w_sof_arm;
            r_hold_data <= vid_data;
            r_sof_pend  <= 1'b0;
          end else begin
            r_hold_vld <= 1'b0;
            r_sof_pend <= w_sof_arm;
          end
        end
        default: begin
          r_state  <= ST_WAIT_VB;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow; a coincident set beats the clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_overflow <= 1'b0;
    end else if (w_ovf) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr] <= w_push_word;
  end

  // FIFO pointers, occupancy and registered stream outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_level  <= '0;
      r_tvalid <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd     <= w_rd_next;
      r_level  <= w_lvl_after_pop + LW'(w_push);
      r_tvalid <= w_tvalid_next;
      r_head   <= w_head_next;
    end
  end

  assign m_axis_video_tvalid = r_tvalid;
  assign m_axis_video_tlast  = r_head[WW-1];
  assign m_axis_video_tuser  = r_head[WW-2];
  assign m_axis_video_tdata  = r_head[DATA_WIDTH-1:0];
  assign locked              = r_locked;
  assign overflow            = r_overflow;
  assign fifo_level          = r_level;

endmodule

// File: tb/tb_vid_in_axi4s_bridge.sv
// Scoreboard bench: stimulus tasks queue the expected beats of each line/frame,
// an independent monitor pops and compares on every accepted stream beat.
module tb_vid_in_axi4s_bridge;

  logic        aclk;
  logic        aresetn;
  logic        vid_ce;
  logic        vid_active_video;
  logic        vid_vblank;
  logic [15:0] vid_data;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic        locked;
  logic        overflow;
  logic        overflow_clr;
  logic [5:0]  fifo_level;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          rdy_mode = 1;   // 0 stall, 1 always ready, 2 random
  logic [17:0] sb [$];         // {tuser, tlast, data}

  vid_in_axi4s_bridge #(.DATA_WIDTH(16), .FIFO_ADDR_BITS(5)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .vid_ce              (vid_ce),
    .vid_active_video    (vid_active_video),
    .vid_vblank          (vid_vblank),
    .vid_data            (vid_data),
    .m_axis_video_tdata  (tdata),
    .m_axis_video_tvalid (tvalid),
    .m_axis_video_tready (tready),
    .m_axis_video_tuser  (tuser),
    .m_axis_video_tlast  (tlast),
    .locked              (locked),
    .overflow            (overflow),
    .overflow_clr        (overflow_clr),
    .fifo_level          (fifo_level)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge aclk);
      if (aresetn && tvalid && tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got data=0x%0h user=%0b last=%0b, expected no beat",
                   tdata, tuser, tlast);
        end else begin
          e = sb.pop_front();
          chk("beat", {14'd0, tuser, tlast, tdata}, {14'd0, e});
        end
      end
    end
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (rdy_mode == 2) tready = 1'($urandom_range(0, 1));
      else               tready = (rdy_mode == 1);
    end
  end

  task automatic set_rdy(input int m);
    rdy_mode = m;
    tready   = (m != 0);
  endtask

  task automatic cyc(input logic ce, input logic act, input logic vb, input logic [15:0] d);
    vid_ce           = ce;
    vid_active_video = act;
    vid_vblank       = vb;
    vid_data         = d;
    @(posedge aclk);
    #1;
  endtask

  // One sample, optionally followed by a junk non-sample cycle.
  task automatic px(input logic act, input logic vb, input logic [15:0] d, input logic toggle);
    cyc(1'b1, act, vb, d);
    if (toggle) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  // Frame of nl lines x np pixels after a vblank; expected beats follow the frame rules.
  task automatic frame(input int nl, input int np, input logic toggle, input logic rnd,
                       input logic [15:0] base, input logic chk_lock);
    logic [15:0] d;
    px(1'b0, 1'b1, 16'h0, toggle);
    px(1'b0, 1'b1, 16'h0, toggle);
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < np; p++) begin
        d = rnd ? 16'($urandom) : 16'(base + 16'(l * np + p));
        sb.push_back({(l == 0 && p == 0), (p == np - 1), d});
        px(1'b1, 1'b0, d, toggle);
        if (chk_lock && l == 0 && p == 0) chk("locked_after_sof", 32'(locked), 32'd1);
      end
      for (int g = 0; g < 3; g++) px(1'b0, 1'b0, 16'h0, toggle);
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(posedge aclk);
      t++;
    end
    @(posedge aclk);
    @(posedge aclk);
    #1;
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    aresetn = 1'b0; overflow_clr = 1'b0;
    vid_ce = 1'b0; vid_active_video = 1'b0; vid_vblank = 1'b0; vid_data = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid",   32'(tvalid),     32'd0);
    chk("rst_tuser",    32'(tuser),      32'd0);
    chk("rst_tlast",    32'(tlast),      32'd0);
    chk("rst_tdata",    32'(tdata),      32'd0);
    chk("rst_locked",   32'(locked),     32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_level",    32'(fifo_level), 32'd0);
    aresetn = 1'b1;

    // Mid-frame start without vblank: nothing is emitted.
    for (int i = 0; i < 6; i++) px(1'b1, 1'b0, 16'(16'h0A0 + i), 1'b0);
    px(1'b0, 1'b0, 16'h0, 1'b0);
    chk("midframe_locked", 32'(locked), 32'd0);
    chk("midframe_level",  32'(fifo_level), 32'd0);

    set_rdy(1);
    frame(2, 4, 1'b0, 1'b0, 16'h0001, 1'b1);
    wait_drain("drain_basic");
    frame(2, 4, 1'b1, 1'b0, 16'h0001, 1'b1);
    wait_drain("drain_ce_toggle");

    set_rdy(2);
    for (int f = 0; f < 6; f++) begin
      frame($urandom_range(1, 3), $urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'b1, 16'h0, 1'b0);
      wait_drain("drain_random");
    end
    chk("no_overflow_random", 32'(overflow), 32'd0);

    // Overflow: 40 pixels into a stalled stream keep only the first 32.
    set_rdy(0);
    px(1'b0, 1'b1, 16'h0, 1'b0);
    px(1'b0, 1'b1, 16'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i < 32) sb.push_back({(i == 0), 1'b0, 16'(16'h0100 + i)});
      px(1'b1, 1'b0, 16'(16'h0100 + i), 1'b0);
    end
    for (int g = 0; g < 3; g++) px(1'b0, 1'b0, 16'h0, 1'b0);
    chk("ovf_level",    32'(fifo_level), 32'd32);
    chk("ovf_flag",     32'(overflow),   32'd1);
    chk("ovf_locked",   32'(locked),     32'd0);
    chk("stall_tdata",  32'(tdata),      32'h0100);
    chk("stall_tuser",  32'(tuser),      32'd1);
    set_rdy(1);
    wait_drain("drain_overflow");
    chk("ovf_level_empty", 32'(fifo_level), 32'd0);
    chk("ovf_still_set",   32'(overflow),   32'd1);
    overflow_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Fill 5 words, check push-to-valid latency, then reset mid-frame.
    set_rdy(0);
    px(1'b0, 1'b1, 16'h0, 1'b0);
    px(1'b1, 1'b0, 16'h0200, 1'b0);
    chk("lat_no_valid", 32'(tvalid), 32'd0);
    px(1'b1, 1'b0, 16'h0201, 1'b0);
    chk("lat_valid", 32'(tvalid), 32'd1);
    for (int i = 2; i < 5; i++) px(1'b1, 1'b0, 16'(16'h0200 + i), 1'b0);
    px(1'b0, 1'b0, 16'h0, 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", 32'(tvalid),     32'd0);
    chk("async_rst_level",  32'(fifo_level), 32'd0);
    sb.delete();
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    set_rdy(1);
    for (int i = 0; i < 5; i++) px(1'b1, 1'b0, 16'(16'h0300 + i), 1'b0);
    px(1'b0, 1'b0, 16'h0, 1'b0);
    chk("post_rst_locked", 32'(locked), 32'd0);
    frame(2, 4, 1'b0, 1'b0, 16'h0011, 1'b1);
    wait_drain("drain_post_rst");
    chk("final_overflow", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
